// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}, active-high before output polarity.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // One register-file entry: displayed hex value plus its decimal point.
    typedef struct packed {
        logic [3:0] value;
        logic       dp;
    } slot_t;

    // Per-cycle scan result before output polarity is applied.
    typedef struct packed {
        logic       lit;
        logic [6:0] seg;
        logic       dp;
    } scan_out_t;

    function automatic logic [6:0] hex_pattern(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to seven-segment decoder (active-high segments).
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    assign o_seg = hex_pattern(i_value);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment controller: register file, digit scan,
// PWM brightness, per-digit enable and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          write,
    input  logic [$clog2(NUM_DIGITS)-1:0] sel,
    input  logic [3:0]                    num,
    input  logic                          dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lz_blank,
    input  logic [3:0]                    bright,
    output logic [6:0]                    segments,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         anode
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_INV  = SEG_ACTIVE_LOW;

    slot_t                 r_slots [NUM_DIGITS];
    logic [PRE_W-1:0]      r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_pwm;
    logic [6:0]            r_segments;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_anode;

    logic                  w_presc_tc;
    logic                  w_idx_last;
    slot_t                 w_cur;
    logic [6:0]            w_dec_seg;
    logic [NUM_DIGITS-1:0] w_nonzero;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS:0]   w_tail_zero;
    logic                  w_suppress;
    scan_out_t             w_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_slots[i] <= '0;
            end
        end else if (write && (int'(sel) < NUM_DIGITS)) begin
            r_slots[sel] <= '{value: num, dp: dp_in};
        end
    end

    assign w_presc_tc = (r_presc == PRE_W'(REFRESH_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_pwm   <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (w_presc_tc) begin
                r_presc <= '0;
                r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nonzero[gi] = |r_slots[gi].value;
            assign w_onehot[gi]  = (r_idx == IDX_W'(gi));
        end
    endgenerate

    // w_tail_zero[i] is set when every digit at index i and above holds zero,
    // i.e. index i lies above the highest nonzero digit.
    always_comb begin
        w_tail_zero = '0;
        w_tail_zero[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_tail_zero[i] = w_tail_zero[i+1] & ~w_nonzero[i];
        end
    end

    assign w_cur      = r_slots[r_idx];
    assign w_suppress = lz_blank && (r_idx != '0) && w_tail_zero[r_idx] && !w_cur.dp;

    hex7seg u_hex7seg (
        .i_value (w_cur.value),
        .o_seg   (w_dec_seg)
    );

    always_comb begin
        w_next     = '{lit: 1'b0, seg: SEG_OFF, dp: 1'b0};
        w_next.lit = digit_en[r_idx] && (r_pwm <= bright) && !w_suppress;
        if (w_next.lit) begin
            w_next.seg = w_dec_seg;
            w_next.dp  = w_cur.dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_anode    <= AN_INV;
            r_segments <= SEG_OFF ^ SEG_INV;
            r_dp       <= DP_INV;
        end else begin
            r_anode    <= (w_next.lit ? w_onehot : '0) ^ AN_INV;
            r_segments <= w_next.seg ^ SEG_INV;
            r_dp       <= w_next.dp ^ DP_INV;
        end
    end

    assign anode    = r_anode;
    assign segments = r_segments;
    assign dp       = r_dp;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised self-checking bench for seg7_scan_ctrl against a cycle-count
// based reference model (8-digit and 6-digit instances, REFRESH_DIV=4).
module tb_seg7_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       write, dp_in, lz_blank;
    logic [2:0] sel;
    logic [3:0] num, bright;
    logic [7:0] digit_en;
    logic [6:0] segments;
    logic       dp;
    logic [7:0] anode;

    logic       write6, dp_in6, lz6;
    logic [2:0] sel6;
    logic [3:0] num6, bright6;
    logic [5:0] digit_en6;
    logic [6:0] seg6;
    logic       dp6;
    logic [5:0] an6;

    seg7_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .write(write), .sel(sel), .num(num),
        .dp_in(dp_in), .digit_en(digit_en), .lz_blank(lz_blank), .bright(bright),
        .segments(segments), .dp(dp), .anode(anode)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(4)) dut6 (
        .clk(clk), .reset_n(reset_n), .write(write6), .sel(sel6), .num(num6),
        .dp_in(dp_in6), .digit_en(digit_en6), .lz_blank(lz6), .bright(bright6),
        .segments(seg6), .dp(dp6), .anode(an6)
    );

    logic [6:0] tb_hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] lit_tab [4] = '{7'b0110000, 7'b0000010, 7'b0010000, 7'b1000110};

    logic [3:0]  mv8 [16];
    logic [3:0]  mv6 [16];
    bit          md8 [16];
    bit          md6 [16];
    int unsigned cyc;
    int          total = 0;
    int          bad = 0;
    int          e_idx;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [5:0]  e_an6;
    logic [6:0]  e_seg6;
    logic        e_dp6;

    // Active-high view of the display given the number of edges since reset.
    function automatic void model(input int n, input int unsigned t,
                                  input logic [3:0] vals [16], input bit dps [16],
                                  input logic [15:0] en, input bit lz, input logic [3:0] br,
                                  output logic [15:0] an, output logic [6:0] seg, output logic o_dp);
        int idx = int'((t / 4) % n);
        int pwm = int'(t % 16);
        int hi = -1;
        bit lit;
        for (int i = 0; i < n; i++) if (vals[i] != 4'd0) hi = i;
        lit = en[idx] && (pwm <= int'(br)) && !(lz && idx > 0 && idx > hi && !dps[idx]);
        an   = lit ? (16'd1 << idx) : 16'd0;
        seg  = lit ? tb_hex[vals[idx]] : 7'd0;
        o_dp = lit && dps[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mv8[i] = 4'd0; mv6[i] = 4'd0; md8[i] = 1'b0; md6[i] = 1'b0;
        end
        cyc = 0;
    endtask

    task automatic tick();
        logic [15:0] a;
        logic [6:0]  s;
        logic        d;
        model(8, cyc, mv8, md8, {8'h00, digit_en}, lz_blank, bright, a, s, d);
        e_an = ~a[7:0]; e_seg = ~s; e_dp = ~d;
        e_idx = int'((cyc / 4) % 8);
        model(6, cyc, mv6, md6, 16'h003F, 1'b0, 4'hF, a, s, d);
        e_an6 = ~a[5:0]; e_seg6 = ~s; e_dp6 = ~d;
        @(posedge clk);
        if (write) begin mv8[sel] = num; md8[sel] = dp_in; end
        if (write6 && sel6 < 3'd6) begin mv6[sel6] = num6; md6[sel6] = dp_in6; end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_model();
        repeat (10) begin
            tick();
            total++;
            if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                bad++; $display("FAIL reset_scan: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", anode, segments, dp, e_an, e_seg, e_dp);
            end
        end
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({anode, segments, dp, an6} !== {8'hFF, 7'h7F, 1'b1, 6'h3F}) begin
            bad++; $display("FAIL reset_async: an=%h seg=%b dp=%b an6=%h want FF 1111111 1 3F", anode, segments, dp, an6);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        clear_model();
        tick();
        total++;
        if ({anode, segments, dp} !== {8'hFE, 7'b1000000, 1'b1}) begin
            bad++; $display("FAIL reset_first_slot: an=%h seg=%b dp=%b want FE 1000000 1", anode, segments, dp);
        end
        $display("reset: first slot an=%h seg=%b", anode, segments);
    endtask

    task automatic test_digits();
        logic [3:0] vals [4] = '{4'h3, 4'h6, 4'h9, 4'hC};
        for (int k = 0; k < 4; k++) begin
            sel = 3'(k); num = vals[k]; dp_in = 1'b0; write = 1'b1;
            tick();
            write = 1'b0;
        end
        repeat (32) begin
            tick();
            total++;
            if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                bad++; $display("FAIL digits_model: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", anode, segments, dp, e_an, e_seg, e_dp);
            end
            if (e_idx < 4) begin
                total++;
                if ({anode, segments} !== {~(8'd1 << e_idx), lit_tab[e_idx]}) begin
                    bad++; $display("FAIL digits_slot%0d: an=%h seg=%b want an=%h seg=%b", e_idx, anode, segments, ~(8'd1 << e_idx), lit_tab[e_idx]);
                end
            end
        end
        $display("digits: 3,6,9,C written and scanned");
    endtask

    task automatic test_wrap();
        logic [7:0] prev = 8'hFF;
        int first = -1;
        int second = -1;
        int slot1 = 0;
        for (int i = 0; i < 80 && second < 0; i++) begin
            tick();
            total++;
            if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                bad++; $display("FAIL wrap_model: an=%h want %h seg=%b want %b", anode, e_an, segments, e_seg);
            end
            if (anode == 8'hFE && prev != 8'hFE) begin
                if (first < 0) first = i; else second = i;
            end
            prev = anode;
        end
        total++;
        if (second < 0 || second - first != 32) begin
            bad++; $display("FAIL wrap_period: got %0d clocks want 32", second - first);
        end
        digit_en = 8'hFD;
        repeat (32) begin
            tick();
            total++;
            if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                bad++; $display("FAIL digit_en_model: an=%h want %h", anode, e_an);
            end
            if (e_idx == 1) begin
                slot1++;
                total++;
                if (anode !== 8'hFF) begin
                    bad++; $display("FAIL digit_en_slot1: an=%h want FF", anode);
                end
            end
        end
        total++;
        if (slot1 != 4) begin
            bad++; $display("FAIL digit_en_slotlen: got %0d want 4", slot1);
        end
        digit_en = 8'hFF;
        $display("wrap: period=%0d clocks", second - first);
    endtask

    task automatic test_lz();
        lz_blank = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            int lo = (pass == 0) ? 4 : 3;
            int shown0 = 0;
            if (pass == 1) begin
                sel = 3'd3; num = 4'h0; dp_in = 1'b0; write = 1'b1;
                tick();
                write = 1'b0;
            end
            repeat (32) begin
                tick();
                total++;
                if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                    bad++; $display("FAIL lz_model: an=%h want %h seg=%b want %b", anode, e_an, segments, e_seg);
                end
                if (e_idx >= lo) begin
                    total++;
                    if (anode !== 8'hFF) begin
                        bad++; $display("FAIL lz_blank_slot%0d: an=%h want FF", e_idx, anode);
                    end
                end
                if (e_idx == 0 && anode === 8'hFE) shown0++;
            end
            total++;
            if (shown0 != 4) begin
                bad++; $display("FAIL lz_digit0: shown %0d clocks want 4", shown0);
            end
            $display("lz: pass %0d blank from slot %0d", pass, lo);
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_bright();
        logic [3:0] levels [2] = '{4'd3, 4'd0};
        for (int b = 0; b < 2; b++) begin
            int on = 0;
            bright = levels[b];
            repeat (16) begin
                tick();
                total++;
                if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                    bad++; $display("FAIL bright_model: an=%h want %h", anode, e_an);
                end
                if (anode !== 8'hFF) on++;
            end
            total++;
            if (on != int'(levels[b]) + 1) begin
                bad++; $display("FAIL bright_duty%0d: on=%0d want %0d", levels[b], on, int'(levels[b]) + 1);
            end
            $display("bright=%0d: lit %0d of 16", levels[b], on);
        end
        bright = 4'hF;
    endtask

    task automatic test_random();
        int errs = 0;
        repeat (400) begin
            write    = ($urandom_range(3) == 0);
            sel      = 3'($urandom_range(7));
            num      = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
            dp_in    = ($urandom_range(4) == 0);
            digit_en = 8'($urandom) | 8'($urandom);
            lz_blank = ($urandom_range(1) == 1);
            bright   = 4'($urandom_range(15));
            tick();
            total++;
            if ({anode, segments, dp} !== {e_an, e_seg, e_dp}) begin
                bad++; errs++;
                $display("FAIL random_model: cyc=%0d an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", cyc, anode, segments, dp, e_an, e_seg, e_dp);
            end
        end
        write = 1'b0; digit_en = 8'hFF; lz_blank = 1'b0; bright = 4'hF;
        $display("random: 400 cycles, %0d errors", errs);
    endtask

    task automatic test_out_of_range();
        int lit = 0;
        for (int k = 0; k < 6; k++) begin
            sel6 = 3'(k); num6 = 4'($urandom_range(1, 14)); dp_in6 = 1'($urandom_range(1)); write6 = 1'b1;
            tick();
        end
        sel6 = 3'd6; num6 = 4'hF; dp_in6 = 1'b1;
        tick();
        sel6 = 3'd7;
        tick();
        write6 = 1'b0;
        repeat (48) begin
            tick();
            total++;
            if ({an6, seg6, dp6} !== {e_an6, e_seg6, e_dp6}) begin
                bad++; $display("FAIL oor_model: an=%h seg=%b dp=%b want an=%h seg=%b dp=%b", an6, seg6, dp6, e_an6, e_seg6, e_dp6);
            end
            if (an6 !== 6'h3F) lit++;
        end
        total++;
        if (lit != 48) begin
            bad++; $display("FAIL oor_lit: lit %0d clocks want 48", lit);
        end
        $display("out_of_range: sel 6/7 writes ignored over two scans");
    endtask

    initial begin
        write = 1'b0; sel = '0; num = '0; dp_in = 1'b0;
        digit_en = 8'hFF; lz_blank = 1'b0; bright = 4'hF;
        write6 = 1'b0; sel6 = '0; num6 = '0; dp_in6 = 1'b0;
        digit_en6 = 6'h3F; lz6 = 1'b0; bright6 = 4'hF;
        test_reset();
        test_digits();
        test_wrap();
        test_lz();
        test_bright();
        test_random();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for the board's common-anode digit bank. It holds a per-digit register file of hex values and decimal points, written one digit per cycle. It scans the digits at a programmable refresh rate and drives the segment and anode lines. Features not offered by fixed 8-digit drivers: per-digit enable, leading-zero blanking, 16-level PWM brightness, and polarity parameters.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..16)
- REFRESH_DIV, 100000, clocks per digit slot (≥2)
- SEG_ACTIVE_LOW, 1, invert segments and dp at output
- AN_ACTIVE_LOW, 1, invert anode at output
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- write  in  1  register-file write strobe, sampled each edge
- sel  in  $clog2(NUM_DIGITS)  digit index for write
- num  in  4  hex value written
- dp_in  in  1  decimal point written with num
- digit_en  in  NUM_DIGITS  per-digit enable, 0 = blanked
- lz_blank  in  1  leading-zero suppression enable
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full
- segments  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- anode  out  NUM_DIGITS  one-hot digit select

## Operation
- Register file: NUM_DIGITS × {value[3:0], dp}. Write on an edge with write=1 stores num/dp_in at sel. sel ≥ NUM_DIGITS: write ignored, no state change.
- Prescaler counts 0..REFRESH_DIV-1. On terminal count, scan index advances; NUM_DIGITS-1 wraps to 0.
- PWM counter: 4-bit, free-running, +1 every clock, wraps 15→0.
- Digit lit when all of:
  - digit_en[idx]=1
  - pwm_cnt ≤ bright
  - not suppressed
- Leading-zero suppression (lz_blank=1): digit idx is suppressed when idx > 0, idx > the highest index holding a nonzero value, and its dp bit is 0. Digit 0 is never suppressed.
- Lit: anode one-hot at idx; segments = hex decode of value (0–F, standard patterns); dp = stored dp.
- Unlit: anode all inactive, segments and dp all off. The slot is still consumed, so scan timing is uniform.
- Polarity parameters apply only at the output register.
- Internal logic is active-high. Example patterns before inversion: 3=1001111, 6=1111101, 9=1101111, C=0111001, 0=0111111.

## Timing
- Reset (async assert, sync-released by clk): register file zeroed, prescaler=0, idx=0, pwm_cnt=0. Outputs all inactive: with defaults, anode=all 1s, segments=7'h7F, dp=1.
- Outputs are registered, computed from the current idx/pwm_cnt/regfile: 1-cycle latency.
- A write at edge E to the displayed digit is visible on segments after edge E+1.
- idx changes at the edge where prescaler wraps; the anode follows one edge later.
- Simultaneous write and scan advance: both take effect; the new digit reads the updated register.
- A mid-scan reset asserts outputs inactive immediately, without waiting for clk.
- digit_en, lz_blank and bright are sampled every cycle, with no slot alignment.

## Structure
- seg7_pkg holds:
  - hex segment pattern constant array [16][7]
  - SEG_OFF constant
  - slot/scan typedefs
- Sub-module hex7seg: 4-bit to 7-bit combinational decoder using the package array.
- Top level holds the register file, prescaler, scan index, PWM counter, blanking logic and output register.

## Test plan
All scenarios use NUM_DIGITS=8, REFRESH_DIV=4, defaults, digit_en=8'hFF and bright=15 unless stated.
- Reset: reset_n=0 mid-scan → anode=8'hFF, segments=7'h7F, dp=1 immediately. After release, first slot shows digit 0 = '0', so anode=8'hFE and segments=7'b1000000.
- Writes 3,6,9,C to sel 0..3 → slot 0: anode 8'hFE, segments 7'b0110000. Slot 1: anode 8'hFD, segments 7'b0000010. Slot 2: anode 8'hFB, segments 7'b0010000. Slot 3: anode 8'hF7, segments 7'b1000110.
- Wrap: index returns to digit 0 exactly 32 clocks after it last entered digit 0. digit_en=8'hFD → anode 8'hFF for all of slot 1.
- Leading-zero: previous data, digits 4..7=0, lz_blank=1 → anode 8'hFF during slots 4–7. Then write 0 to sel 3 → slots 3–7 blank; digit 0 is still shown.
- Brightness: bright=3 → anode active exactly 4 of every 16 clocks. bright=0 → 1 of 16.
- Out of range: NUM_DIGITS=6 instance, write sel=6 num=F → no register changes; all six digits unchanged across a full scan.
